// File: rtl/asg_pkg.sv
// asg_pkg: types and defaults shared by the arithmetic sequence generator stages.
//   ASG_ADDR_W / ASG_DATA_W : default sequence RAM address and term widths.
//   asg_rd_state_e          : readback FSM state encoding.
//   asg_fifo_entry_t        : stream buffer entry {data, last}.
package asg_pkg;

    localparam int unsigned ASG_ADDR_W = 10;
    localparam int unsigned ASG_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } asg_rd_state_e;

    typedef struct packed {
        logic [ASG_DATA_W-1:0] data;
        logic                  last;
    } asg_fifo_entry_t;

endpackage

// File: rtl/asg_stream_fifo.sv
// asg_stream_fifo: small synchronous FIFO carrying {data, last} stream entries.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, wdata_i  write an entry (must not be full)
//   pop_i, rdata_o   remove the head entry; rdata_o shows the head (valid when !empty_o)
//   count_o          current occupancy
//   full_o, empty_o  occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module asg_stream_fifo
    import asg_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = asg_fifo_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

    pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/asg_seq_reader.sv
// asg_seq_reader: reads a stored arithmetic sequence back from the shared sequence RAM
// and streams the terms out in address order on a valid/ready interface.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, n                    level start; n (term count) latched when start is accepted
//   mem_read_enable/mem_address RAM read strobe and address
//   mem_read_data               RAM data, valid one cycle after mem_read_enable
//   out_valid/out_data/out_last stream output (registered), out_ready from the sink
//   busy, done                  busy in READ/DRAIN, done in DONE
// Optional (macro ASG_SEQ_READER_CHECK_EN):
//   a1, d                       first term and step, latched with n
//   check_err, err_index        sticky mismatch flag and first mismatching term index
// The output register sits in front of the FIFO, so "fifo_count" excludes the beat currently
// presented; this lets the registered-only issue rule sustain one beat per cycle.
module asg_seq_reader
    import asg_pkg::*;
#(
    parameter int unsigned ADDR_W     = ASG_ADDR_W,
    parameter int unsigned DATA_W     = ASG_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       n,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef ASG_SEQ_READER_CHECK_EN
    ,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] d,
    output logic              check_err,
    output logic [ADDR_W-1:0] err_index
`endif
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CntRW = ADDR_W + 1;
    localparam logic [31:0] DepthN = 32'd1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } rd_entry_t;

    asg_rd_state_e    state_q, state_d;
    logic [CntRW-1:0] n_eff_q, n_eff_d;
    logic [CntRW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CntRW-1:0] push_cnt_q, push_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic             inflight_q, inflight_d;
    logic             out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [CntRW-1:0] n_eff, n_eff_m1;
    logic [CntW-1:0]  fifo_count;
    logic [CntW:0]    occ;
    logic             start_acc, issue, last_issue, push, pop_out, out_free;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    rd_entry_t        push_entry, fifo_rdata;

    assign n_eff     = (n > DepthN) ? {1'b1, {ADDR_W{1'b0}}} : n[CntRW-1:0];
    assign n_eff_m1  = n_eff_q - CntRW'(1);
    assign start_acc = (state_q == StIdle) && start;

    // Issue decision looks only at registered state: no path from out_ready.
    assign occ        = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    assign issue      = (state_q == StRead) && (occ < (CntW + 1)'(FIFO_DEPTH));
    assign last_issue = issue && (rd_cnt_q == n_eff_m1);

    // Data returns the cycle after issue.
    assign push            = inflight_q;
    assign push_entry.data = mem_read_data;
    assign push_entry.last = (push_cnt_q == n_eff_m1);

    always_comb begin
        state_d    = state_q;
        n_eff_d    = n_eff_q;
        rd_cnt_d   = rd_cnt_q;
        push_cnt_d = push_cnt_q;
        addr_d     = addr_q;
        inflight_d = issue;

        case (state_q)
            StIdle: begin
                if (start) begin
                    n_eff_d    = n_eff;
                    rd_cnt_d   = '0;
                    push_cnt_d = '0;
                    addr_d     = '0;
                    state_d    = (n_eff == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            rd_cnt_d = rd_cnt_q + CntRW'(1);
            // Hold the final address rather than wrapping past the top of the RAM.
            if (!last_issue) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (push) begin
            push_cnt_d = push_cnt_q + CntRW'(1);
        end
    end

    // Output register: refill from the FIFO head first, else bypass the returning word.
    always_comb begin
        pop_out     = out_valid_q && out_ready;
        out_free    = !out_valid_q || pop_out;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        fifo_pop    = 1'b0;
        fifo_push   = 1'b0;
        if (out_free) begin
            if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                fifo_push   = push;
                out_valid_d = 1'b1;
                out_data_d  = fifo_rdata.data;
                out_last_d  = fifo_rdata.last;
            end else if (push) begin
                out_valid_d = 1'b1;
                out_data_d  = push_entry.data;
                out_last_d  = push_entry.last;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            fifo_push = push;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            n_eff_q     <= '0;
            rd_cnt_q    <= '0;
            push_cnt_q  <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_eff_q     <= n_eff_d;
            rd_cnt_q    <= rd_cnt_d;
            push_cnt_q  <= push_cnt_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    asg_stream_fifo #(
        .Depth   (FIFO_DEPTH),
        .entry_t (rd_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

    assign mem_read_enable = issue;
    assign mem_address     = addr_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_last        = out_last_q;
    assign busy            = (state_q == StRead) || (state_q == StDrain);
    assign done            = (state_q == StDone);

`ifdef ASG_SEQ_READER_CHECK_EN
    // Expected term tracked as a running sum a1 + k*d (wraps modulo 2**DATA_W).
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_idx_q, err_idx_d;

    always_comb begin
        exp_d     = exp_q;
        step_d    = step_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        if (start_acc) begin
            exp_d     = a1;
            step_d    = d;
            err_d     = 1'b0;
            err_idx_d = '0;
        end else if (push) begin
            exp_d = exp_q + step_q;
            if (!err_q && (mem_read_data != exp_q)) begin
                err_d     = 1'b1;
                err_idx_d = push_cnt_q[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= '0;
            step_q    <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            exp_q     <= exp_d;
            step_q    <= step_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign check_err = err_q;
    assign err_index = err_idx_q;
`endif

endmodule
